// File: rtl/alu_types.sv
// alu_types: ALU operation encoding shared by the RV32I integer execution slice.
// Contents: alu_control_t, the 4-bit ALU operation code driven by the core FSM.
package alu_types;

    typedef enum logic [3:0] {
        ALU_INVALID = 4'b0000,
        ALU_AND     = 4'b0001,
        ALU_OR      = 4'b0010,
        ALU_XOR     = 4'b0011,
        ALU_SLL     = 4'b0101,
        ALU_SRL     = 4'b0110,
        ALU_SRA     = 4'b0111,
        ALU_ADD     = 4'b1000,
        ALU_SUB     = 4'b1100,
        ALU_SLT     = 4'b1101,
        ALU_SLTU    = 4'b1111
    } alu_control_t;

endpackage

// File: rtl/register_file.sv
// register_file: 32x32 RV32I architectural register file, x0 hardwired to zero.
// Ports: clk, rst (sync, active-high) | wr_ena, wr_addr[4:0], wr_data[31:0] write port
//        | rd_addr0/rd_addr1[4:0] in, rd_data0/rd_data1[31:0] out (asynchronous reads).
// Config: REGFILE_BYPASS_EN forwards wr_data to a read port addressing the register
//         being written in the same cycle.
module register_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ena,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr0,
    input  logic [4:0]  rd_addr1,
    output logic [31:0] rd_data0,
    output logic [31:0] rd_data1
);

    logic [31:0] regs [32];
    logic        wr_live;

    // x0 is never written, so regs[0] stays at its reset value of zero
    assign wr_live = wr_ena && (wr_addr != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign rd_data0 = (rd_addr0 == 5'd0) ? '0 : (wr_live && rd_addr0 == wr_addr) ? wr_data : regs[rd_addr0];
    assign rd_data1 = (rd_addr1 == 5'd0) ? '0 : (wr_live && rd_addr1 == wr_addr) ? wr_data : regs[rd_addr1];
`else
    assign rd_data0 = (rd_addr0 == 5'd0) ? '0 : regs[rd_addr0];
    assign rd_data1 = (rd_addr1 == 5'd0) ? '0 : regs[rd_addr1];
`endif

endmodule

// File: rtl/rv32i_alu_regfile.sv
// rv32i_alu_regfile: integer execution slice of the RV32I multicycle core.
// Ports: clk, rst (sync, active-high)
//        | wr_ena, wr_addr[4:0], wr_data[31:0]: register-file write port
//        | rd_addr0/rd_addr1[4:0] in, rd_data0/rd_data1[31:0] out: async reads
//        | reg_a/reg_b[31:0] out: operand registers, reload every cycle
//        | src_b_imm, imm[31:0]: operand B select (1 = imm, 0 = reg_b)
//        | alu_control[3:0] (alu_control_t), alu_ena: ALU op and alu_last load enable
//        | alu_result[31:0], overflow, zero, equal, alu_last[31:0] out
// Config: REGFILE_BYPASS_EN (see register_file) enables same-cycle write forwarding.
module rv32i_alu_regfile
    import alu_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_ena,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [4:0]  rd_addr0,
    input  logic [4:0]  rd_addr1,
    output logic [31:0] rd_data0,
    output logic [31:0] rd_data1,
    output logic [31:0] reg_a,
    output logic [31:0] reg_b,
    input  logic        src_b_imm,
    input  logic [31:0] imm,
    input  logic [3:0]  alu_control,
    input  logic        alu_ena,
    output logic [31:0] alu_result,
    output logic        overflow,
    output logic        zero,
    output logic        equal,
    output logic [31:0] alu_last
);

    alu_control_t op;
    logic [31:0]  src_b;

    register_file u_register_file (
        .clk      (clk),
        .rst      (rst),
        .wr_ena   (wr_ena),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a    <= '0;
            reg_b    <= '0;
            alu_last <= '0;
        end else begin
            reg_a <= rd_data0;
            reg_b <= rd_data1;
            if (alu_ena) alu_last <= alu_result;
        end
    end

    assign op    = alu_control_t'(alu_control);
    assign src_b = src_b_imm ? imm : reg_b;

    always_comb begin
        alu_result = '0;
        overflow   = 1'b0;
        case (op)
            ALU_AND:  alu_result = reg_a & src_b;
            ALU_OR:   alu_result = reg_a | src_b;
            ALU_XOR:  alu_result = reg_a ^ src_b;
            ALU_SLL:  alu_result = reg_a << src_b[4:0];
            ALU_SRL:  alu_result = reg_a >> src_b[4:0];
            ALU_SRA:  alu_result = $unsigned($signed(reg_a) >>> src_b[4:0]);
            ALU_ADD: begin
                alu_result = reg_a + src_b;
                overflow   = (reg_a[31] == src_b[31]) && (alu_result[31] != reg_a[31]);
            end
            ALU_SUB: begin
                alu_result = reg_a - src_b;
                overflow   = (reg_a[31] != src_b[31]) && (alu_result[31] != reg_a[31]);
            end
            ALU_SLT:  alu_result = {31'd0, $signed(reg_a) < $signed(src_b)};
            ALU_SLTU: alu_result = {31'd0, reg_a < src_b};
            default:  alu_result = '0;
        endcase
    end

    assign zero  = (alu_result == 32'd0);
    assign equal = (reg_a == src_b);

endmodule

// File: tb/tb_rv32i_alu_regfile.sv
// tb_rv32i_alu_regfile: scoreboard bench for rv32i_alu_regfile with a behavioural model.
module tb_rv32i_alu_regfile;

    logic        clk = 1'b0;
    logic        rst, wr_ena, src_b_imm, alu_ena;
    logic [4:0]  wr_addr, rd_addr0, rd_addr1;
    logic [31:0] wr_data, imm;
    logic [3:0]  alu_control;
    logic [31:0] rd_data0, rd_data1, reg_a, reg_b, alu_result, alu_last;
    logic        overflow, zero, equal;

    rv32i_alu_regfile dut (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_data0(rd_data0), .rd_data1(rd_data1),
        .reg_a(reg_a), .reg_b(reg_b), .src_b_imm(src_b_imm), .imm(imm),
        .alu_control(alu_control), .alu_ena(alu_ena), .alu_result(alu_result),
        .overflow(overflow), .zero(zero), .equal(equal), .alu_last(alu_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd0, rd1, a, b, res, last;
        logic        ovf, zf, eq;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_a, m_b, m_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference ALU from the arithmetic definitions, using wide signed integers.
    task automatic alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic v);
        longint sa, sb_, full;
        sa = longint'($signed(a));
        sb_ = longint'($signed(b));
        r = 0;
        v = 0;
        case (op)
            4'd1: r = a & b;
            4'd2: r = a | b;
            4'd3: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = 32'(sa >>> b[4:0]);
            4'd8, 4'd12: begin
                full = (op == 4'd8) ? sa + sb_ : sa - sb_;
                r = full[31:0];
                v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'd13: r = (sa < sb_) ? 32'd1 : 32'd0;
            4'd15: r = ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
            default: r = 0;
        endcase
    endtask

    function automatic logic [31:0] rd_ref(input logic [4:0] ra);
        if (ra == 0) return 0;
`ifdef REGFILE_BYPASS_EN
        if (wr_ena && wr_addr == ra) return wr_data;
`endif
        return m_regs[ra];
    endfunction

    // Record the expected outputs for the current inputs, then advance the model one edge.
    task automatic step();
        exp_t        e;
        logic [31:0] bb;
        e.rd0 = rd_ref(rd_addr0);
        e.rd1 = rd_ref(rd_addr1);
        e.a = m_a;
        e.b = m_b;
        e.last = m_last;
        bb = src_b_imm ? imm : m_b;
        alu_ref(alu_control, m_a, bb, e.res, e.ovf);
        e.zf = (e.res == 0);
        e.eq = (m_a == bb);
        sb.push_back(e);
        if (rst) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_a = 0;
            m_b = 0;
            m_last = 0;
        end else begin
            if (alu_ena) m_last = e.res;
            m_a = e.rd0;
            m_b = e.rd1;
            if (wr_ena && wr_addr != 0) m_regs[wr_addr] = wr_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; wr_ena = 0; alu_ena = 0; src_b_imm = 0;
        wr_addr = 0; wr_data = 0; imm = 0; alu_control = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        idle();
        wr_ena = 1; wr_addr = a; wr_data = d;
        step();
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rd_data0", rd_data0, e.rd0);
            chk("rd_data1", rd_data1, e.rd1);
            chk("reg_a", reg_a, e.a);
            chk("reg_b", reg_b, e.b);
            chk("alu_result", alu_result, e.res);
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("zero", 32'(zero), 32'(e.zf));
            chk("equal", 32'(equal), 32'(e.eq));
            chk("alu_last", alu_last, e.last);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        idle();
        rd_addr0 = 0; rd_addr1 = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        foreach (m_regs[i]) m_regs[i] = 0;
        m_a = 0; m_b = 0; m_last = 0;
        // reset after writes
        rd_addr0 = 5; rd_addr1 = 5;
        wr(5, 32'hDEADBEEF);
        idle(); alu_control = 4'd8; alu_ena = 1; step();
        idle(); rst = 1; wr_ena = 1; wr_addr = 5; wr_data = 32'h1; step();
        idle(); step();
        // x0 and x31
        rd_addr0 = 0;
        wr(0, 32'h1234);
        idle(); step();
        rd_addr0 = 31; rd_addr1 = 31;
        wr(31, 32'hFFFFFFFF);
        idle(); step();
        step();
        // ADD overflow
        rd_addr0 = 1; wr(1, 32'h7FFFFFFF); step();
        idle(); src_b_imm = 1; imm = 1; alu_control = 4'd8; step();
        // SUB equal operands
        rd_addr0 = 2; rd_addr1 = 2; wr(2, 5); step();
        idle(); alu_control = 4'd12; step();
        // shifts
        rd_addr0 = 4; wr(4, 32'h80000000); step();
        idle(); src_b_imm = 1; imm = 32'h24; alu_control = 4'd7; step();
        alu_control = 4'd6; step();
        // signed/unsigned compare
        rd_addr0 = 6; rd_addr1 = 7; wr(6, 32'hFFFFFFFF); wr(7, 1); step();
        idle(); alu_control = 4'd13; step();
        alu_control = 4'd15; step();
        // write while reading the same register
        rd_addr0 = 3; rd_addr1 = 3;
        wr(3, 7);
        idle(); step();
        step();
        // alu_last hold and load
        idle(); alu_control = 4'd8; src_b_imm = 1; imm = 32'h10; alu_ena = 1; step();
        alu_ena = 0; imm = 32'h55; rd_addr0 = 31; step();
        step();
        alu_ena = 1; step();
        idle(); step();
        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 60) == 0);
            wr_ena = $urandom_range(0, 1);
            wr_addr = 5'($urandom);
            case ($urandom_range(0, 3))
                0: wr_data = 32'h80000000 ^ 32'($urandom_range(0, 3));
                1: wr_data = 32'h7FFFFFFF - 32'($urandom_range(0, 3));
                2: wr_data = 32'($urandom_range(0, 8));
                default: wr_data = $urandom;
            endcase
            rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            rd_addr1 = ($urandom_range(0, 3) == 0) ? rd_addr0 : 5'($urandom);
            src_b_imm = $urandom_range(0, 1);
            imm = $urandom_range(0, 1) ? 32'($urandom_range(0, 63)) : $urandom;
            alu_control = 4'($urandom);
            alu_ena = $urandom_range(0, 1);
            step();
        end
        idle();
        repeat (4) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
